// File: rtl/trace_pkg.sv
// Shared encodings and record layout for the commit-trace producer.
package trace_pkg;

  localparam int KIND_W = 2;
  localparam int REG_W  = 3;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int REC_W  = KIND_W + REG_W + ADDR_W + DATA_W;  // 37

  typedef enum logic [KIND_W-1:0] {
    KIND_REG   = 2'd0,
    KIND_LOAD  = 2'd1,
    KIND_STORE = 2'd2,
    KIND_HALT  = 2'd3
  } kind_t;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [2:0] SEL_CYCLES = 3'd0;
  localparam logic [2:0] SEL_INST   = 3'd1;
  localparam logic [2:0] SEL_ICHIT  = 3'd2;
  localparam logic [2:0] SEL_ICREQ  = 3'd3;
  localparam logic [2:0] SEL_DCHIT  = 3'd4;
  localparam logic [2:0] SEL_DCREQ  = 3'd5;
  localparam int         NUM_CNT    = 6;

  typedef struct packed {
    kind_t              kind;
    logic [REG_W-1:0]   rreg;
    logic [ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]  data;
  } rec_t;

  function automatic logic [REC_W-1:0] make_rec(
    input kind_t             kind,
    input logic [REG_W-1:0]  rreg,
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] data
  );
    return {kind, rreg, addr, data};
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// First-word fall-through FIFO accepting up to three in-order pushes and one pop per cycle.
module trace_fifo
  import trace_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = REC_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               push_cnt,
  input  logic [W-1:0]             push_data [3],
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   occ
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_pop;

  assign valid  = (occ != '0);
  assign do_pop = pop & valid;
  assign head   = mem[rd_ptr];

  // Storage carries no reset; the top gates the head with valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (i < int'(push_cnt)) begin
        mem[wr_ptr + AW'(i)] <= push_data[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push_cnt);
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      occ <= occ + (AW+1)'(push_cnt) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/commit_trace_unit.sv
// Commit-trace producer: packs retire events into trace records, keeps
// saturating perf counters and reports completion once halt has drained.
module commit_trace_unit
  import trace_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ev_regwrite,
  input  logic [2:0]        ev_wreg,
  input  logic [15:0]       ev_wdata,
  input  logic              ev_memread,
  input  logic              ev_memwrite,
  input  logic [15:0]       ev_addr,
  input  logic [15:0]       ev_wrdata,
  input  logic [15:0]       ev_rddata,
  input  logic              ev_halt,
  input  logic [15:0]       ev_pc,
  input  logic              icache_req,
  input  logic              icache_hit,
  input  logic              dcache_req,
  input  logic              dcache_hit,
  output logic              trace_stall,
  output logic              tr_valid,
  input  logic              tr_ready,
  output logic [1:0]        tr_kind,
  output logic [2:0]        tr_reg,
  output logic [15:0]       tr_addr,
  output logic [15:0]       tr_data,
  input  logic [2:0]        cnt_sel,
  output logic [CNT_W-1:0]  cnt_val,
  output logic              done
);

  localparam int OW = $clog2(FIFO_DEPTH) + 1;

  state_t              state;
  state_t              state_nxt;
  logic                accept;
  logic [OW-1:0]       occ;
  logic [OW-1:0]       free;
  logic                fifo_valid;
  logic [REC_W-1:0]    fifo_head;
  rec_t                head_rec;
  logic [REC_W-1:0]    push_data [3];
  logic [1:0]          n_push;
  logic [1:0]          push_cnt;
  logic [REC_W-1:0]    reg_rec;
  logic [REC_W-1:0]    mem_rec;
  logic [REC_W-1:0]    halt_rec;
  logic                has_mem;
  logic [NUM_CNT-1:0]  inc;
  logic [CNT_W-1:0]    cnt [NUM_CNT];

  // Free space uses registered occupancy only, so stall never depends on ev_*.
  assign free = OW'(FIFO_DEPTH) - occ;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:   if (accept && ev_halt) state_nxt = ST_DRAIN;
      ST_DRAIN: if (occ == '0)         state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_DONE;
      default:  state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    trace_stall = (state == ST_RUN) && (free < OW'(3));
    accept      = (state == ST_RUN) && !trace_stall;
    done        = (state == ST_DONE);
  end

  assign has_mem  = ev_memwrite | ev_memread;
  assign reg_rec  = make_rec(KIND_REG, ev_wreg, 16'h0000, ev_wdata);
  assign mem_rec  = ev_memwrite ? make_rec(KIND_STORE, 3'd0, ev_addr, ev_wrdata)
                                : make_rec(KIND_LOAD,  3'd0, ev_addr, ev_rddata);
  assign halt_rec = make_rec(KIND_HALT, 3'd0, ev_pc, 16'h0000);

  always_comb begin
    push_data[0] = ev_regwrite ? reg_rec : (has_mem ? mem_rec : halt_rec);
    push_data[1] = ev_regwrite ? (has_mem ? mem_rec : halt_rec) : halt_rec;
    push_data[2] = halt_rec;
    n_push       = {1'b0, ev_regwrite} + {1'b0, has_mem} + {1'b0, ev_halt};
    push_cnt     = accept ? n_push : 2'd0;
  end

  trace_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (REC_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_cnt  (push_cnt),
    .push_data (push_data),
    .pop       (tr_ready),
    .head      (fifo_head),
    .valid     (fifo_valid),
    .occ       (occ)
  );

  always_comb begin
    head_rec = fifo_valid ? rec_t'(fifo_head) : '0;
    tr_valid = fifo_valid;
    tr_kind  = head_rec.kind;
    tr_reg   = head_rec.rreg;
    tr_addr  = head_rec.addr;
    tr_data  = head_rec.data;
  end

  always_comb begin
    inc             = '0;
    inc[SEL_CYCLES] = (state == ST_RUN);
    inc[SEL_INST]   = accept & (ev_halt | ev_regwrite | ev_memwrite);
    inc[SEL_ICHIT]  = accept & icache_hit;
    inc[SEL_ICREQ]  = accept & icache_req;
    inc[SEL_DCHIT]  = accept & dcache_hit;
    inc[SEL_DCREQ]  = accept & dcache_req;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CNT; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CNT; i++) begin
        if (inc[i] && (cnt[i] != '1)) cnt[i] <= cnt[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_val <= '0;
    end else begin
      case (cnt_sel)
        SEL_CYCLES: cnt_val <= cnt[SEL_CYCLES];
        SEL_INST:   cnt_val <= cnt[SEL_INST];
        SEL_ICHIT:  cnt_val <= cnt[SEL_ICHIT];
        SEL_ICREQ:  cnt_val <= cnt[SEL_ICREQ];
        SEL_DCHIT:  cnt_val <= cnt[SEL_DCHIT];
        SEL_DCREQ:  cnt_val <= cnt[SEL_DCREQ];
        default:    cnt_val <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_commit_trace_unit.sv
// Scoreboard bench for commit_trace_unit: expected records are queued as events are accepted.
module tb_commit_trace_unit;

  localparam int DEPTH = 8;
  localparam int CW    = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ev_regwrite = 0, ev_memread = 0, ev_memwrite = 0, ev_halt = 0;
  logic [2:0]  ev_wreg = '0;
  logic [15:0] ev_wdata = '0, ev_addr = '0, ev_wrdata = '0, ev_rddata = '0, ev_pc = '0;
  logic        icache_req = 0, icache_hit = 0, dcache_req = 0, dcache_hit = 0;
  logic        trace_stall, tr_valid, done;
  logic        tr_ready = 0;
  logic [1:0]  tr_kind;
  logic [2:0]  tr_reg;
  logic [15:0] tr_addr, tr_data;
  logic [2:0]  cnt_sel = '0;
  logic [CW-1:0] cnt_val;

  int total = 0;
  int bad   = 0;
  int m_inst = 0, m_ichit = 0, m_icreq = 0, m_dchit = 0, m_dcreq = 0;
  logic [36:0] exp_q [$];
  logic [36:0] sb_exp;

  always #5 clk = ~clk;

  commit_trace_unit #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .ev_regwrite(ev_regwrite), .ev_wreg(ev_wreg), .ev_wdata(ev_wdata),
    .ev_memread(ev_memread), .ev_memwrite(ev_memwrite), .ev_addr(ev_addr),
    .ev_wrdata(ev_wrdata), .ev_rddata(ev_rddata), .ev_halt(ev_halt), .ev_pc(ev_pc),
    .icache_req(icache_req), .icache_hit(icache_hit),
    .dcache_req(dcache_req), .dcache_hit(dcache_hit),
    .trace_stall(trace_stall), .tr_valid(tr_valid), .tr_ready(tr_ready),
    .tr_kind(tr_kind), .tr_reg(tr_reg), .tr_addr(tr_addr), .tr_data(tr_data),
    .cnt_sel(cnt_sel), .cnt_val(cnt_val), .done(done)
  );

  // Scoreboard: every handshake pops and compares the oldest expected record.
  always @(negedge clk) begin
    if (!rst && tr_valid && tr_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_extra: got record %h, expected none", {tr_kind, tr_reg, tr_addr, tr_data});
      end else begin
        sb_exp = exp_q.pop_front();
        if ({tr_kind, tr_reg, tr_addr, tr_data} !== sb_exp) begin
          bad++;
          $display("FAIL sb_record: got %h, expected %h", {tr_kind, tr_reg, tr_addr, tr_data}, sb_exp);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ev();
    ev_regwrite = 0; ev_memread = 0; ev_memwrite = 0; ev_halt = 0;
    icache_req = 0; icache_hit = 0; dcache_req = 0; dcache_hit = 0;
  endtask

  task automatic push_expected();
    if (ev_regwrite) exp_q.push_back({2'd0, ev_wreg, 16'h0000, ev_wdata});
    if (ev_memwrite) exp_q.push_back({2'd2, 3'd0, ev_addr, ev_wrdata});
    else if (ev_memread) exp_q.push_back({2'd1, 3'd0, ev_addr, ev_rddata});
    if (ev_halt) exp_q.push_back({2'd3, 3'd0, ev_pc, 16'h0000});
    if (ev_halt || ev_regwrite || ev_memwrite) m_inst++;
    if (icache_hit) m_ichit++;
    if (icache_req) m_icreq++;
    if (dcache_hit) m_dchit++;
    if (dcache_req) m_dcreq++;
  endtask

  // Hold the current events until the unit stops stalling, then log them as accepted.
  task automatic commit_ev(input int budget);
    int tries = 0;
    forever begin
      @(negedge clk);
      if (!trace_stall) break;
      tries++;
      if (tries >= budget) begin
        total++; bad++;
        $display("FAIL accept_timeout: trace_stall=1 after %0d cycles, required 0", tries);
        break;
      end
    end
    if (!trace_stall) push_expected();
    step();
    clear_ev();
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    forever begin
      @(negedge clk);
      if (exp_q.size() == 0 && !tr_valid) break;
      n++;
      if (n >= budget) begin
        total++; bad++;
        $display("FAIL drain_timeout: %0d records outstanding, tr_valid=%0b, required 0/0", exp_q.size(), tr_valid);
        break;
      end
    end
    #1;
  endtask

  task automatic read_cnt(input logic [2:0] sel, output logic [CW-1:0] val);
    cnt_sel = sel;
    step();
    val = cnt_val;
  endtask

  task automatic test_reset();
    #1 rst = 1;
    #2;
    total++; if (tr_valid !== 1'b0)    begin bad++; $display("FAIL rst_valid: got %b, expected 0", tr_valid); end
    total++; if (trace_stall !== 1'b0) begin bad++; $display("FAIL rst_stall: got %b, expected 0", trace_stall); end
    total++; if (done !== 1'b0)        begin bad++; $display("FAIL rst_done: got %b, expected 0", done); end
    total++; if (cnt_val !== '0)       begin bad++; $display("FAIL rst_cnt: got %h, expected 0", cnt_val); end
    total++; if ({tr_kind, tr_reg, tr_addr, tr_data} !== 37'h0)
      begin bad++; $display("FAIL rst_fields: got %h, expected 0", {tr_kind, tr_reg, tr_addr, tr_data}); end
    step();
    rst = 0;
    step();
  endtask

  task automatic test_regwrite();
    logic [CW-1:0] v;
    tr_ready = 1;
    ev_regwrite = 1; ev_wreg = 3'd3; ev_wdata = 16'h1234;
    commit_ev(4);
    total++;
    if ({tr_valid, tr_kind, tr_reg, tr_data} !== {1'b1, 2'd0, 3'd3, 16'h1234}) begin
      bad++;
      $display("FAIL reg_head: got v=%b k=%0d r=%0d d=%h, expected v=1 k=0 r=3 d=1234", tr_valid, tr_kind, tr_reg, tr_data);
    end
    wait_drain(10);
    read_cnt(3'd1, v);
    total++; if (v !== CW'(m_inst)) begin bad++; $display("FAIL inst_after_reg: got %0d, expected %0d", v, m_inst); end
  endtask

  task automatic test_store_priority();
    logic [CW-1:0] v;
    ev_memread = 1; ev_memwrite = 1; ev_addr = 16'h0100; ev_wrdata = 16'hAAAA; ev_rddata = 16'h5555;
    commit_ev(4);
    wait_drain(10);
    read_cnt(3'd1, v);
    total++; if (v !== CW'(m_inst)) begin bad++; $display("FAIL inst_store_prio: got %0d, expected %0d", v, m_inst); end
  endtask

  task automatic test_cache_counters();
    logic [CW-1:0] v, a;
    logic [CW-1:0] exp_c [6];
    for (int i = 0; i < 5; i++) begin
      icache_req = 1; icache_hit = (i % 2 == 1); dcache_req = (i < 3); dcache_hit = (i == 1);
      commit_ev(4);
    end
    exp_c[2] = CW'(m_ichit); exp_c[3] = CW'(m_icreq); exp_c[4] = CW'(m_dchit); exp_c[5] = CW'(m_dcreq);
    for (int s = 2; s < 6; s++) begin
      read_cnt(3'(s), v);
      total++; if (v !== exp_c[s]) begin bad++; $display("FAIL cache_cnt sel=%0d: got %0d, expected %0d", s, v, exp_c[s]); end
    end
    for (int s = 6; s < 8; s++) begin
      read_cnt(3'(s), v);
      total++; if (v !== '0) begin bad++; $display("FAIL unused_sel sel=%0d: got %0d, expected 0", s, v); end
    end
    read_cnt(3'd0, a);
    read_cnt(3'd0, v);
    total++; if (v !== a + CW'(1)) begin bad++; $display("FAIL cycles_inc: got %0d, expected %0d", v, a + CW'(1)); end
  endtask

  task automatic test_stall_wrap();
    tr_ready = 0;
    for (int i = 0; i < 6; i++) begin
      ev_memwrite = 1; ev_addr = 16'h1000 + 16'(i); ev_wrdata = 16'hC000 + 16'(i * 3);
      commit_ev(4);
      if (i == 4) begin
        @(negedge clk);
        total++; if (trace_stall !== 1'b0) begin bad++; $display("FAIL stall_at5: got %b, expected 0", trace_stall); end
        step();
      end
    end
    @(negedge clk);
    total++; if (trace_stall !== 1'b1) begin bad++; $display("FAIL stall_at6: got %b, expected 1", trace_stall); end
    total++; if ({tr_kind, tr_reg, tr_addr, tr_data} !== exp_q[0])
      begin bad++; $display("FAIL head_hold: got %h, expected %h", {tr_kind, tr_reg, tr_addr, tr_data}, exp_q[0]); end
    step();
    fork
      begin
        for (int i = 6; i < 9; i++) begin
          ev_memwrite = 1; ev_addr = 16'h1000 + 16'(i); ev_wrdata = 16'hC000 + 16'(i * 3);
          commit_ev(30);
        end
      end
      begin
        repeat (6) step();
        tr_ready = 1;
      end
    join
    wait_drain(30);
  endtask

  task automatic test_reset_mid();
    logic [CW-1:0] v;
    tr_ready = 0;
    for (int i = 0; i < 5; i++) begin
      ev_regwrite = 1; ev_wreg = 3'(i); ev_wdata = 16'h5000 + 16'(i);
      commit_ev(4);
    end
    #2 rst = 1;
    #1;
    total++; if (tr_valid !== 1'b0)    begin bad++; $display("FAIL midrst_valid: got %b, expected 0", tr_valid); end
    total++; if (cnt_val !== '0)       begin bad++; $display("FAIL midrst_cnt: got %h, expected 0", cnt_val); end
    total++; if (trace_stall !== 1'b0 || done !== 1'b0)
      begin bad++; $display("FAIL midrst_state: got stall=%b done=%b, expected 0/0", trace_stall, done); end
    exp_q.delete();
    m_inst = 0; m_ichit = 0; m_icreq = 0; m_dchit = 0; m_dcreq = 0;
    step();
    rst = 0;
    read_cnt(3'd1, v);
    total++; if (v !== '0) begin bad++; $display("FAIL midrst_inst: got %0d, expected 0", v); end
    total++; if (tr_valid !== 1'b0) begin bad++; $display("FAIL midrst_empty: got %b, expected 0", tr_valid); end
  endtask

  task automatic test_halt();
    logic [CW-1:0] c0, v;
    int n;
    tr_ready = 0;
    ev_regwrite = 1; ev_wreg = 3'd5; ev_wdata = 16'hBEEF;
    ev_memread = 1; ev_addr = 16'h0040; ev_rddata = 16'hBEEF;
    ev_halt = 1; ev_pc = 16'h0022;
    commit_ev(4);
    total++; if (exp_q.size() != 3 || {tr_kind, tr_reg, tr_addr, tr_data} !== exp_q[0])
      begin bad++; $display("FAIL halt_head: got %h, expected %h", {tr_kind, tr_reg, tr_addr, tr_data}, exp_q[0]); end
    read_cnt(3'd0, c0);
    ev_regwrite = 1; ev_memwrite = 1; ev_halt = 1; icache_req = 1; icache_hit = 1;
    repeat (4) step();
    clear_ev();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL drain_done: got %b, expected 0", done); end
    read_cnt(3'd0, v);
    total++; if (v !== c0) begin bad++; $display("FAIL drain_cycles: got %0d, expected %0d", v, c0); end
    read_cnt(3'd1, v);
    total++; if (v !== CW'(m_inst)) begin bad++; $display("FAIL drain_inst: got %0d, expected %0d", v, m_inst); end
    read_cnt(3'd3, v);
    total++; if (v !== CW'(m_icreq)) begin bad++; $display("FAIL drain_icreq: got %0d, expected %0d", v, m_icreq); end
    tr_ready = 1;
    wait_drain(10);
    n = 0;
    while (done !== 1'b1 && n < 10) begin step(); n++; end
    total++; if (done !== 1'b1) begin bad++; $display("FAIL done: got %b, expected 1", done); end
    ev_regwrite = 1; ev_memwrite = 1; ev_halt = 1; dcache_req = 1;
    repeat (10) step();
    clear_ev();
    read_cnt(3'd0, v);
    total++; if (v !== c0) begin bad++; $display("FAIL done_cycles: got %0d, expected %0d", v, c0); end
    total++; if (tr_valid !== 1'b0 || done !== 1'b1)
      begin bad++; $display("FAIL done_idle: got valid=%b done=%b, expected 0/1", tr_valid, done); end
  endtask

  initial begin
    test_reset();
    test_regwrite();
    test_store_priority();
    test_cache_counters();
    test_stall_wrap();
    test_reset_mid();
    test_halt();
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL leftover: got %0d records pending, expected 0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/commit_trace_unit.md
Name: commit_trace_unit

Overview:
- Synthesizable producer side of the processor's commit-trace/statistics interface.
- Lives inside proc_hier next to the memory/writeback stages. Each cycle it captures retire events (register write, load, store, halt) and cache request/hit strobes.
- Packs the events into trace records in a FIFO, which an external consumer drains over a valid/ready port.
- Keeps saturating performance counters and freezes them once halt has drained.

Parameters:
- FIFO_DEPTH, 8, number of trace record entries; power of two, ≥4.
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- ev_regwrite  in  1  register file written this cycle
- ev_wreg  in  3  register written
- ev_wdata  in  16  register write data
- ev_memread  in  1  load completed this cycle
- ev_memwrite  in  1  store completed this cycle
- ev_addr  in  16  memory address
- ev_wrdata  in  16  store data
- ev_rddata  in  16  load data
- ev_halt  in  1  halt retired
- ev_pc  in  16  PC of the retiring instruction
- icache_req, icache_hit, dcache_req, dcache_hit  in  1 each  cache strobes
- trace_stall  out  1  processor must hold all ev_* and cache strobes
- tr_valid  out  1  head record valid
- tr_ready  in  1  consumer accepts head
- tr_kind  out  2  0=REG 1=LOAD 2=STORE 3=HALT
- tr_reg  out  3  register field
- tr_addr  out  16  address field
- tr_data  out  16  data field
- cnt_sel  in  3  counter select
- cnt_val  out  CNT_W  selected counter, registered
- done  out  1  halt accepted and FIFO drained

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high. Reset is allowed mid-operation and discards all pending records.
- Reset values: FIFO empty, tr_valid=0, tr_* = 0, trace_stall=0, counters=0, cnt_val=0, done=0, state=RUN.
- States: RUN, DRAIN, DONE.
  - RUN→DRAIN when an accepted cycle has ev_halt=1.
  - DRAIN→DONE when the FIFO is empty.
  - DONE holds until reset.
- trace_stall is 1 only in RUN when free entries < 3.
  - free is computed from the registered occupancy only, so it never depends on the ev_* inputs (no combinational loop).
  - Same-cycle pops are not credited.
- Accepted cycle: state=RUN and trace_stall=0. In non-accepted cycles all ev_* and cache inputs are ignored. Inputs in DRAIN/DONE are always ignored.
- Records pushed in an accepted cycle, in this FIFO order:
  - REG: reg=ev_wreg, addr=0, data=ev_wdata.
  - Then LOAD (addr=ev_addr, data=ev_rddata) or STORE (addr=ev_addr, data=ev_wrdata).
    - ev_memwrite has priority. If ev_memread and ev_memwrite are both 1, only STORE is pushed.
  - Then HALT: reg=0, addr=ev_pc, data=0.
  - At most 3 pushes per cycle.
- FIFO: first-word fall-through.
  - tr_* reflect the head whenever tr_valid=1.
  - A pop occurs when tr_valid & tr_ready.
  - Push and pop may happen in the same cycle.
  - Pointers wrap modulo FIFO_DEPTH.
  - tr_* must stay stable while tr_valid & !tr_ready.
- Counters (saturate at all-ones, update only in accepted cycles, except as noted):
  - cycles: +1 every RUN cycle, including stalled ones.
  - inst: +1 if ev_halt|ev_regwrite|ev_memwrite.
  - ichit, icreq, dchit, dcreq: +1 on their strobes.
  - All counters freeze outside RUN.
- cnt_val: registered, 1-cycle latency from cnt_sel.
  - 0=cycles, 1=inst, 2=ichit, 3=icreq, 4=dchit, 5=dcreq.
  - 6 and 7 return 0.
- done = (state==DONE), asserted the cycle after the FIFO becomes empty while in DRAIN.

Decomposition:
- trace_pkg holds:
  - the kind encodings REG/LOAD/STORE/HALT;
  - the state encodings;
  - the cnt_sel encodings;
  - the record field widths, with total record width 37 bits.
- One sub-module, trace_fifo: multi-push (0–3 per cycle, in order), single pop, occupancy output.
- The top level holds the FSM, the event-to-record packing, the counters and the cnt_val mux.

Test Plan:
- Reset release, tr_ready=1, one cycle of ev_regwrite=1, wreg=3, wdata=0x1234 → next cycle tr_valid=1, kind=0, reg=3, data=0x1234; inst count reads 1 via cnt_sel=1 one cycle later.
- Single cycle with regwrite (r5=0xBEEF), memread (addr=0x0040, rddata=0xBEEF) and halt (pc=0x0022), tr_ready=0:
  - FIFO holds REG, LOAD, HALT in that order.
  - trace_stall=1 when DEPTH=4.
  - After tr_ready=1 they drain in 3 cycles, then done=1.
- tr_ready=0 while 6 store cycles are driven, DEPTH=8 → stall asserts once occupancy reaches 6; further events are held, not lost. Release tr_ready → all stores emerge in order with correct addr/data across pointer wrap.
- memread=1 and memwrite=1 together → only a STORE record is produced; inst +1.
- Assert rst for one cycle with 5 records queued → tr_valid=0 immediately (async), counters=0, state RUN.
- Events after halt acceptance → no records pushed; counters frozen; cnt_sel=0 value unchanged across 10 cycles.
